// File: rtl/lcd_pkg.sv
// Shared constants, sweep state encoding and beat payload for the LCD text buffer.
package lcd_pkg;

  localparam int unsigned LCD_COLS   = 16;
  localparam int unsigned LCD_LINES  = 2;
  localparam int unsigned LCD_CELLS  = LCD_COLS * LCD_LINES;
  localparam int unsigned CELL_AW    = 5;
  localparam int unsigned COL_W      = 4;
  localparam int unsigned HEX_W      = 32;
  localparam int unsigned HEX_IDX_W  = 3;

  localparam logic [7:0] LCD_CMD_LINE0    = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE1    = 8'hC0;
  localparam logic [7:0] ASCII_SPACE      = 8'h20;
  localparam logic [7:0] ASCII_ZERO       = 8'h30;
  // 'A' - 10, so nibble 10..15 maps straight onto 'A'..'F'
  localparam logic [7:0] ASCII_ALPHA_BASE = 8'h37;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    CHAR
  } sweep_state_e;

  // One beat towards the nibble driver: RS flag plus command/character byte.
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_beat_t;

  // Flat cell index from line/column.
  function automatic logic [CELL_AW-1:0] cell_idx(input logic line, input logic [COL_W-1:0] col);
    return {line, col};
  endfunction

endpackage

// File: rtl/lcd_hex_ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
//   nibble_i : 4-bit value 0..15
//   ascii_o  : '0'..'9' or 'A'..'F'
module lcd_hex_ascii
  import lcd_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    if (nibble_i < 4'd10) ascii_o = ASCII_ZERO + 8'(nibble_i);
    else                  ascii_o = ASCII_ALPHA_BASE + 8'(nibble_i);
  end

endmodule

// File: rtl/lcd_text_buffer.sv
// 2x16 character frame buffer that replays the whole frame to the LCD
// nibble driver as address commands plus data bytes whenever it changes.
//   clk, reset         : clock, async active-high reset
//   wr_en/addr/data    : single character write ({line, col} addressing)
//   hex_en/line/value  : render 32-bit value as 8 hex digits into cols 8..15
//   busy               : hex render in progress
//   out_valid/ready    : beat handshake towards the nibble driver
//   out_rs, out_byte   : RS flag and command/character byte
module lcd_text_buffer
  import lcd_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [CELL_AW-1:0] wr_addr,
  input  logic [7:0]         wr_data,
  input  logic               hex_en,
  input  logic               hex_line,
  input  logic [HEX_W-1:0]   hex_value,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_rs,
  output logic [7:0]         out_byte
);

  logic [7:0]           cells_q [LCD_CELLS];
  logic [7:0]           cells_d [LCD_CELLS];
  logic                 dirty_q, dirty_d;
  logic                 busy_q, busy_d;
  logic [HEX_W-1:0]     hex_val_q, hex_val_d;
  logic                 hex_line_q, hex_line_d;
  logic [HEX_IDX_W-1:0] hex_idx_q, hex_idx_d;
  sweep_state_e         state_q, state_d;
  logic                 line_q, line_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic                 valid_q, valid_d;
  lcd_beat_t            beat_q, beat_d;

  logic [7:0]           hex_char;
  logic [CELL_AW-1:0]   hex_addr;
  logic                 write_any;
  logic                 accept;

  // Digit source is always the top nibble; the value shifts left per digit.
  lcd_hex_ascii u_hex_ascii (
    .nibble_i (hex_val_q[HEX_W-1 -: 4]),
    .ascii_o  (hex_char)
  );

  assign hex_addr  = cell_idx(hex_line_q, {1'b1, hex_idx_q});
  assign write_any = wr_en | busy_q;
  assign accept    = valid_q & out_ready;

  // Hex render sequencer: latch on hex_en when idle, then 8 digit writes.
  always_comb begin
    busy_d     = busy_q;
    hex_val_d  = hex_val_q;
    hex_line_d = hex_line_q;
    hex_idx_d  = hex_idx_q;
    if (busy_q) begin
      hex_val_d = {hex_val_q[HEX_W-5:0], 4'h0};
      hex_idx_d = hex_idx_q + 3'd1;
      if (hex_idx_q == 3'd7) busy_d = 1'b0;
    end else if (hex_en) begin
      busy_d     = 1'b1;
      hex_val_d  = hex_value;
      hex_line_d = hex_line;
      hex_idx_d  = '0;
    end
  end

  // Cell array update; the hex write is applied last so it wins a collision.
  always_comb begin
    cells_d = cells_q;
    if (wr_en)  cells_d[wr_addr]  = wr_data;
    if (busy_q) cells_d[hex_addr] = hex_char;
  end

  // Sweep FSM: the output register holds the beat currently presented.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    col_d   = col_q;
    valid_d = valid_q;
    beat_d  = beat_q;
    dirty_d = dirty_q;
    case (state_q)
      IDLE: begin
        if (dirty_q) begin
          state_d = ADDR;
          line_d  = 1'b0;
          valid_d = 1'b1;
          beat_d  = '{rs: 1'b0, data: LCD_CMD_LINE0};
          dirty_d = 1'b0;
        end
      end
      ADDR: begin
        if (accept) begin
          state_d = CHAR;
          col_d   = '0;
          beat_d  = '{rs: 1'b1, data: cells_q[cell_idx(line_q, 4'd0)]};
        end
      end
      CHAR: begin
        if (accept) begin
          if (col_q != 4'(LCD_COLS - 1)) begin
            col_d  = col_q + 4'd1;
            beat_d = '{rs: 1'b1, data: cells_q[cell_idx(line_q, col_q + 4'd1)]};
          end else if (!line_q) begin
            state_d = ADDR;
            line_d  = 1'b1;
            beat_d  = '{rs: 1'b0, data: LCD_CMD_LINE1};
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    // A write in the same cycle as the clear keeps the frame pending.
    if (write_any) dirty_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(LCD_CELLS); i++) cells_q[i] <= ASCII_SPACE;
      dirty_q    <= 1'b1;
      busy_q     <= 1'b0;
      hex_val_q  <= '0;
      hex_line_q <= 1'b0;
      hex_idx_q  <= '0;
      state_q    <= IDLE;
      line_q     <= 1'b0;
      col_q      <= '0;
      valid_q    <= 1'b0;
      beat_q     <= '0;
    end else begin
      cells_q    <= cells_d;
      dirty_q    <= dirty_d;
      busy_q     <= busy_d;
      hex_val_q  <= hex_val_d;
      hex_line_q <= hex_line_d;
      hex_idx_q  <= hex_idx_d;
      state_q    <= state_d;
      line_q     <= line_d;
      col_q      <= col_d;
      valid_q    <= valid_d;
      beat_q     <= beat_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_rs    = beat_q.rs;
  assign out_byte  = beat_q.data;

endmodule

// File: doc/lcd_text_buffer.md
# lcd_text_buffer

32-character (2×16) text frame buffer that sits directly upstream of the board's character-LCD nibble driver. Processor-side logic writes ASCII bytes, or a 32-bit value rendered as 8 hex digits, into the buffer. Whenever the contents change, the block replays the whole frame to the downstream driver as a byte stream: set-address commands plus data bytes, over a valid/ready handshake. The downstream driver owns nibble splitting, E pulsing and LCD timing.

## Interface
- No parameters; geometry is fixed at 2 lines × 16 columns.
- clk  in  1  50 MHz system clock; every register is on its rising edge.
- reset  in  1  asynchronous, active-high.
- wr_en  in  1  single-character write strobe.
- wr_addr  in  5  cell index; [4] selects the line, [3:0] the column.
- wr_data  in  8  ASCII byte.
- hex_en  in  1  start hex render; ignored while busy=1.
- hex_line  in  1  target line for the hex render.
- hex_value  in  32  value to render.
- busy  out  1  hex render in progress.
- out_valid  out  1  a beat is presented to the downstream driver.
- out_ready  in  1  downstream driver accepts the beat.
- out_rs  out  1  0 = command byte, 1 = data byte (LCD RS).
- out_byte  out  8  command or character byte.

## Operation
- Storage: 32×8 register array. Reset loads every cell with 0x20 (space).
- Character write: when wr_en=1, wr_data lands in cell wr_addr at the next edge.
- Hex render:
  - On hex_en with busy=0, latch hex_value and hex_line, then set busy=1.
  - Over the next 8 cycles, write one ASCII hex digit per cycle to columns 8..15 of the latched line, most-significant nibble first.
  - Digits 0-9 map to 0x30-0x39; A-F map to 0x41-0x46 (uppercase).
  - busy drops after the 8th write.
- Write conflict: if a hex write and wr_en target the same cell in the same cycle, the hex write wins and the wr_en write is dropped. Writes to different cells both complete.
- Dirty flag:
  - Set by any completed write; reset also sets it.
  - Cleared on the IDLE→ADDR transition.
  - A write during a sweep sets it again, so exactly one further sweep follows.
- Sweep FSM states: IDLE, ADDR, CHAR.
  - IDLE: out_valid=0. If dirty=1, go to ADDR with line=0.
  - ADDR: present out_rs=0, out_byte=0x80 for line 0 or 0xC0 for line 1. On accept, go to CHAR with col=0.
  - CHAR: present out_rs=1 and out_byte = cell{line,col}. On accept with col<15, increment col. On accept with col=15 and line=0, go to ADDR with line=1. On accept with col=15 and line=1, go to IDLE.
- A sweep is 34 beats: 0x80, 16 characters, 0xC0, 16 characters.
- Character bytes are sampled from the array when the beat is loaded into the output register. A write to that cell after loading affects only the next sweep.
- Handshake rules:
  - A beat transfers on a cycle where out_valid=1 and out_ready=1.
  - While out_valid=1 and out_ready=0, out_rs and out_byte hold stable.
  - out_valid never drops without a transfer, except on reset.
- Reset mid-sweep: the FSM returns to IDLE, out_valid clears immediately (asynchronously), the array returns to spaces and dirty=1. A fresh full sweep then follows. The downstream driver must tolerate a truncated sequence.

## Timing
- Reset values: out_valid=0, out_rs=0, out_byte=0x00, busy=0, FSM=IDLE, dirty=1.
- All outputs are registered; there is no combinational path from out_ready to any output.
- out_valid rises 1 cycle after IDLE samples dirty=1.
- With out_ready held at 1, one beat transfers per cycle, so a sweep takes 34 cycles. IDLE then lasts at least 1 cycle before the next sweep.
- After an accept, the next beat is presented in the following cycle.
- Hex render: hex_en at cycle 0 produces writes at cycles 1-8, and busy is high for cycles 1-8. A hex_en sampled during cycles 1-8 is ignored; a hex_en at cycle 9 or later starts a new render.
- Write latency: a cell updates 1 cycle after the strobe.

## Structure
- Package lcd_pkg holds:
  - LCD_CMD_LINE0 = 8'h80, LCD_CMD_LINE1 = 8'hC0, ASCII_SPACE = 8'h20.
  - The sweep state enum {IDLE, ADDR, CHAR}.
  - Constants LCD_COLS = 16 and LCD_LINES = 2.
- One sub-module: lcd_hex_ascii, a combinational 4-bit nibble → 8-bit ASCII converter used by the hex render path.

## Test plan
- Reset release, out_ready=1 → the first 34 beats are (0,0x80), 16×(1,0x20), (0,0xC0), 16×(1,0x20), then out_valid=0.
- wr_en addr=5'd17, data=0x41 while idle → the next sweep's beat 20 (column 1 of line 1) is (1,0x41); all other characters are 0x20.
- hex_en line=0, value=0xDEADBEEF → line 0, columns 8-15 read "DEADBEEF" (0x44,0x45,0x41,0x44,0x42,0x45,0x45,0x46); busy is high for exactly 8 cycles; a second hex_en at cycle 4 has no effect.
- out_ready toggled randomly during a sweep → the beat sequence is identical to the back-to-back case, and payload never changes while out_valid=1 and out_ready=0.
- Write during a sweep, and a same-cycle hex/wr_en collision on column 8 → the hex digit wins; exactly one additional sweep follows, showing the new contents.
- Reset asserted at beat 10 → out_valid=0 asynchronously; after release, a full 34-beat sweep of spaces.
